serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor: the inverse-direction counterpart of the team's combinational full adder. It computes diff = a - b one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It sits beside the adder datapath as an area-cheap multi-cycle arithmetic unit with a start/busy/done handshake.

---
 rtl/arith_pkg.sv | 13 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 96 +++++++++
 tb/tb_serial_subtractor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the bit-serial datapath units.
// Holds the sequencer state encoding and the default operand width.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
// Purely combinational; the serial unit registers the borrow around it.
module full_subtractor
   import arith_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first,
// with a start/busy/done handshake and a registered borrow between bits.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-2:0] r_sh;
   logic [WIDTH-1:0] r_nxt;
   logic             borrow;
   logic [CW-1:0]    cnt;
   logic             d;
   logic             bout;
   logic             accept;
   logic             last;

   full_subtractor u_fs (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (borrow),
      .d    (d),
      .bout (bout)
   );

   // start is honoured in IDLE and DONE; a running operation is never re-sampled
   assign accept = start && (state != RUN);
   assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
   // r_sh keeps the bits already produced; the new bit enters from the MSB side
   assign r_nxt  = {d, r_sh};

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh       <= '0;
         b_sh       <= '0;
         r_sh       <= '0;
         borrow     <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b;
         borrow <= 1'b0;
         cnt    <= '0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         r_sh   <= r_nxt[WIDTH-1:1];
         borrow <= bout;
         cnt    <= cnt + 1'b1;
         // outputs only move on the completion edge and hold otherwise
         if (last) begin
            diff       <= r_nxt;
            borrow_out <= bout;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 (directed) and WIDTH=4
// (exhaustive), using expected-result queues popped on each done pulse.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0, diff8;
   logic       busy8, done8, bor8;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0, diff4;
   logic       busy4, done4, bor4;

   int checks = 0;
   int errors = 0;
   int n_done4 = 0;
   logic [8:0] q8[$];
   logic [4:0] q4[$];
   logic prev_done8 = 1'b0, prev_done4 = 1'b0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bor8)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bor4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard side: every done pulse pops one expected {borrow, diff}
   always @(negedge clk) begin
      if (rst_n && done8) begin
         if (q8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
         else chk("result8", {23'd0, bor8, diff8}, {23'd0, q8.pop_front()});
         if (prev_done8) chk("done8_width", 32'd2, 32'd1);
      end
      if (rst_n && done4) begin
         n_done4++;
         if (q4.size() == 0) chk("done4_unexpected", 32'd1, 32'd0);
         else chk("result4", {27'd0, bor4, diff4}, {27'd0, q4.pop_front()});
         if (prev_done4) chk("done4_width", 32'd2, 32'd1);
      end
      prev_done8 = done8;
      prev_done4 = done4;
   end

   function automatic logic [8:0] exp8(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] dd;
      dd = x - y;
      return {(x < y), dd};
   endfunction

   function automatic logic [4:0] exp4(input logic [3:0] x, input logic [3:0] y);
      logic [3:0] dd;
      dd = x - y;
      return {(x < y), dd};
   endfunction

   task automatic wait_done8(output int c);
      c = 0;
      do begin
         @(posedge clk); #1; c++;
      end while (!done8 && c < 100);
      if (!done8) chk("timeout8", 32'd0, 32'd1);
   endtask

   task automatic wait_done4(output int c);
      c = 0;
      do begin
         @(posedge clk); #1; c++;
      end while (!done4 && c < 100);
      if (!done4) chk("timeout4", 32'd0, 32'd1);
   endtask

   task automatic run8(input logic [7:0] x, input logic [7:0] y);
      int c;
      a8 = x; b8 = y; start8 = 1'b1;
      q8.push_back(exp8(x, y));
      @(posedge clk); #1;
      start8 = 1'b0;
      wait_done8(c);
      chk("latency8", c, 8);
   endtask

   task automatic run4(input logic [3:0] x, input logic [3:0] y);
      int c;
      a4 = x; b4 = y; start4 = 1'b1;
      q4.push_back(exp4(x, y));
      @(posedge clk); #1;
      start4 = 1'b0;
      wait_done4(c);
   endtask

   initial begin
      int c;
      logic seen;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_diff", diff8, 0);
      chk("rst_borrow", bor8, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // first op with cycle-by-cycle handshake timing
      a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
      q8.push_back(exp8(8'h05, 8'h03));
      @(posedge clk); #1;
      start8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("busy_run%0d", i), busy8, 1);
         chk($sformatf("nodone_run%0d", i), done8, 0);
         @(posedge clk); #1;
      end
      chk("busy_at_done", busy8, 0);
      chk("done_at_k8", done8, 1);
      @(posedge clk); #1;
      chk("done_cleared", done8, 0);
      chk("diff_hold", diff8, 8'h02);

      run8(8'h03, 8'h05);
      run8(8'h00, 8'hFF);
      run8(8'hFF, 8'hFF);
      run8(8'h80, 8'h01);

      // start held through RUN with changing operands, then back-to-back
      a8 = 8'h40; b8 = 8'h11; start8 = 1'b1;
      q8.push_back(exp8(8'h40, 8'h11));
      q8.push_back(exp8(8'h99, 8'h22));
      @(posedge clk); #1;
      a8 = 8'h99; b8 = 8'h22;
      wait_done8(c);
      chk("b2b_first_latency", c, 8);
      c = 0;
      do begin
         @(posedge clk); #1; c++;
         if (c == 1) begin
            start8 = 1'b0;
            chk("b2b_restart_busy", busy8, 1);
         end
      end while (!done8 && c < 100);
      chk("b2b_done_spacing", c, 9);
      @(posedge clk); #1;

      // reset in the 4th RUN cycle aborts the op without a done pulse
      a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("pre_abort_busy", busy8, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy8, 0);
      chk("abort_done", done8, 0);
      chk("abort_diff", diff8, 0);
      chk("abort_borrow", bor8, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done8) seen = 1'b1;
      end
      chk("abort_no_done", seen, 0);
      chk("abort_idle_busy", busy8, 0);
      run8(8'h10, 8'h01);
      chk("post_abort_diff", diff8, 8'h0F);

      // exhaustive WIDTH=4 sweep
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            run4(4'(x), 4'(y));
      @(posedge clk); #1;
      chk("done4_count", n_done4, 256);
      chk("q4_drained", q4.size(), 0);
      chk("q8_drained", q8.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
